// File: rtl/mac_unit_simd_if.sv
// mac_unit_simd_if: request/result bundle between the EX decode and the SIMD MAC
interface mac_unit_simd_if #(
   parameter int DATA_W = 32,
   parameter int LANES  = 1
);
   logic                    en;
   logic                    mul_mac_signal;
   logic                    clr;
   logic [LANES*DATA_W-1:0] a;
   logic [LANES*DATA_W-1:0] b;
   logic [LANES*DATA_W-1:0] o;
   logic                    out_valid;
   logic [LANES-1:0]        ovf;
   modport master (
      output en, mul_mac_signal, clr, a, b,
      input  o, out_valid, ovf
   );
   modport slave (
      input  en, mul_mac_signal, clr, a, b,
      output o, out_valid, ovf
   );
endinterface

// File: rtl/mac_unit_simd.sv
// mac_unit_simd: 2-stage signed SIMD multiply-accumulate with saturation and sticky overflow
module mac_unit_simd #(
   parameter int DATA_W   = 32,
   parameter int LANES    = 1,
   parameter int ACC_W    = 2*DATA_W+8,
   parameter bit SATURATE = 1'b1
) (
   input logic            clk,
   input logic            rst,
   mac_unit_simd_if.slave mac_if
);
   localparam int PW = 2*DATA_W;
   localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SMIN = ~SMAX;
   logic signed [PW-1:0]    prod_q [LANES];
   logic signed [PW-1:0]    prod_d [LANES];
   logic                    en_s1_q, mode_s1_q, clr_s1_q;
   logic signed [ACC_W-1:0] acc_q [LANES];
   logic signed [ACC_W-1:0] acc_d [LANES];
   logic signed [ACC_W-1:0] pext [LANES];
   logic                    fits [LANES];
   logic [DATA_W-1:0]       fitv [LANES];
   logic [LANES*DATA_W-1:0] o_q, o_d;
   logic [LANES-1:0]        ovf_q, ovf_d;
   logic                    out_valid_q;
   logic                    upd;
   // full-width signed lane products
   always_comb begin
      for (int l = 0; l < LANES; l++)
         prod_d[l] = PW'($signed(mac_if.a[l*DATA_W +: DATA_W])) * PW'($signed(mac_if.b[l*DATA_W +: DATA_W]));
   end
   // stage 1: capture products only on en; clr travels alongside so it stays ordered with ops
   always_ff @(posedge clk) begin
      if (!rst) begin
         prod_q    <= '{default: '0};
         en_s1_q   <= 1'b0;
         mode_s1_q <= 1'b0;
         clr_s1_q  <= 1'b0;
      end else begin
         en_s1_q  <= mac_if.en;
         clr_s1_q <= mac_if.clr;
         if (mac_if.en) begin
            prod_q    <= prod_d;
            mode_s1_q <= mac_if.mul_mac_signal;
         end
      end
   end
   // stage 2 next state: accumulate, fit result to DATA_W, track out-of-range sums
   always_comb begin
      upd   = en_s1_q | clr_s1_q;
      o_d   = o_q;
      ovf_d = ovf_q;
      for (int l = 0; l < LANES; l++) begin
         pext[l]  = ACC_W'(prod_q[l]);
         acc_d[l] = clr_s1_q ? (en_s1_q ? pext[l] : '0)
                  : en_s1_q  ? (mode_s1_q ? acc_q[l] + pext[l] : pext[l])
                  : acc_q[l];
         fits[l]  = (acc_d[l][ACC_W-1:DATA_W-1] == '0) || (acc_d[l][ACC_W-1:DATA_W-1] == '1);
         fitv[l]  = (SATURATE && !fits[l]) ? (acc_d[l][ACC_W-1] ? SMIN : SMAX) : acc_d[l][DATA_W-1:0];
         o_d[l*DATA_W +: DATA_W] = upd ? fitv[l] : o_q[l*DATA_W +: DATA_W];
         ovf_d[l] = (~clr_s1_q & ovf_q[l]) | (upd & ~fits[l]);
      end
   end
   // stage 2 registers: accumulators, result, flags and the valid strobe
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q       <= '{default: '0};
         o_q         <= '0;
         ovf_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         o_q         <= o_d;
         ovf_q       <= ovf_d;
         out_valid_q <= en_s1_q;
      end
   end
   assign mac_if.o         = o_q;
   assign mac_if.ovf       = ovf_q;
   assign mac_if.out_valid = out_valid_q;
endmodule

// File: tb/tb_mac_unit_simd.sv
// tb_mac_unit_simd: directed checks of the SIMD MAC in three configurations
module tb_mac_unit_simd;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   mac_unit_simd_if #(.DATA_W(32), .LANES(1)) i0 ();
   mac_unit_simd_if #(.DATA_W(32), .LANES(1)) i1 ();
   mac_unit_simd_if #(.DATA_W(8),  .LANES(4)) i2 ();
   mac_unit_simd #(.DATA_W(32), .LANES(1), .SATURATE(1'b1)) d0 (.clk(clk), .rst(rst), .mac_if(i0));
   mac_unit_simd #(.DATA_W(32), .LANES(1), .SATURATE(1'b0)) d1 (.clk(clk), .rst(rst), .mac_if(i1));
   mac_unit_simd #(.DATA_W(8),  .LANES(4), .SATURATE(1'b1)) d2 (.clk(clk), .rst(rst), .mac_if(i2));
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic drv0(input logic en, input logic mode, input logic clr, input logic [31:0] a, input logic [31:0] b);
      i0.en = en; i0.mul_mac_signal = mode; i0.clr = clr; i0.a = a; i0.b = b;
   endtask
   initial begin
      drv0(0, 0, 0, 0, 0);
      i1.en = 0; i1.mul_mac_signal = 0; i1.clr = 0; i1.a = 0; i1.b = 0;
      i2.en = 0; i2.mul_mac_signal = 0; i2.clr = 0; i2.a = 0; i2.b = 0;
      rst = 1'b0;
      step();
      step();
      chk("rst_o", i0.o, 0);
      chk("rst_valid", i0.out_valid, 0);
      chk("rst_ovf", i0.ovf, 0);
      chk("rst_o_simd", i2.o, 0);
      rst = 1'b1;
      step();
      drv0(1, 1, 1, 32'hFFFFFFF6, 1);
      step();
      drv0(1, 1, 0, 1, 8);
      step();
      chk("t1_clr_op_o", i0.o, 64'hFFFFFFF6);
      chk("t1_clr_op_valid", i0.out_valid, 1);
      chk("t1_clr_op_ovf", i0.ovf, 0);
      drv0(0, 0, 0, 0, 0);
      step();
      chk("t1_mac_o", i0.o, 64'hFFFFFFFE);
      chk("t1_mac_ovf", i0.ovf, 0);
      step();
      chk("t1_valid_drop", i0.out_valid, 0);
      drv0(0, 0, 1, 0, 0);
      step();
      drv0(1, 1, 0, 3, 4);
      step();
      chk("t2_clr_o", i0.o, 0);
      chk("t2_clr_valid", i0.out_valid, 0);
      drv0(1, 1, 0, 5, 6);
      step();
      chk("t2_mac1_o", i0.o, 12);
      chk("t2_mac1_valid", i0.out_valid, 1);
      drv0(1, 1, 0, 32'hFFFFFFFE, 7);
      step();
      chk("t2_mac2_o", i0.o, 42);
      chk("t2_mac2_valid", i0.out_valid, 1);
      drv0(0, 0, 0, 0, 0);
      step();
      chk("t2_mac3_o", i0.o, 28);
      chk("t2_mac3_valid", i0.out_valid, 1);
      step();
      chk("t2_valid_drop", i0.out_valid, 0);
      drv0(1, 0, 1, 32'h7FFFFFFF, 2);
      step();
      drv0(1, 1, 0, 32'h80000001, 2);
      step();
      chk("t3_sat_o", i0.o, 64'h7FFFFFFF);
      chk("t3_sat_ovf", i0.ovf, 1);
      drv0(0, 0, 1, 0, 0);
      step();
      chk("t3_back_o", i0.o, 0);
      chk("t3_sticky_ovf", i0.ovf, 1);
      drv0(0, 0, 0, 0, 0);
      step();
      chk("t3_clr_o", i0.o, 0);
      chk("t3_clr_ovf", i0.ovf, 0);
      chk("t3_clr_valid", i0.out_valid, 0);
      i1.en = 1; i1.mul_mac_signal = 0; i1.clr = 1; i1.a = 32'h40000000; i1.b = 4;
      step();
      i1.en = 0; i1.clr = 0;
      step();
      chk("t4_trunc_o", i1.o, 0);
      chk("t4_trunc_ovf", i1.ovf, 1);
      chk("t4_trunc_valid", i1.out_valid, 1);
      i2.en = 1; i2.mul_mac_signal = 0; i2.a = 32'h7FF003FF; i2.b = 32'h020205FF;
      step();
      i2.mul_mac_signal = 1;
      step();
      chk("t5_mul_o", i2.o, 64'h7FE00F01);
      chk("t5_mul_ovf", i2.ovf, 4'b1000);
      i2.en = 0;
      step();
      chk("t5_mac_o", i2.o, 64'h7FC01E02);
      chk("t5_mac_ovf", i2.ovf, 4'b1000);
      chk("t5_mac_valid", i2.out_valid, 1);
      drv0(1, 0, 0, 5, 5);
      step();
      drv0(0, 0, 0, 0, 0);
      step();
      chk("t6_pre_o", i0.o, 25);
      drv0(1, 1, 0, 2, 2);
      step();
      drv0(0, 0, 0, 0, 0);
      rst = 1'b0;
      step();
      chk("t6_rst_valid", i0.out_valid, 0);
      chk("t6_rst_o", i0.o, 0);
      rst = 1'b1;
      step();
      chk("t6_after_valid", i0.out_valid, 0);
      chk("t6_after_o", i0.o, 0);
      chk("t6_after_ovf", i0.ovf, 0);
      drv0(1, 1, 0, 2, 3);
      step();
      drv0(0, 0, 0, 0, 0);
      step();
      chk("t6_mac_o", i0.o, 6);
      chk("t6_mac_valid", i0.out_valid, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
